key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter NKEYS, default 4: number of debounced key inputs served, 1..8.
REQ-002 Parameter LONG_CYCLES, default 16: hold cycles (>=2) from press to long-press event.
REQ-003 Parameter REPEAT_CYCLES, default 8: cycles (>=2) between auto-repeat events.
REQ-004 Parameter FIFO_DEPTH, default 4: event queue entries, power of two, >=2.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 nrst  input  1  asynchronous active-low reset.
REQ-007 key_in  input  NKEYS  debounced key levels, 1 = pressed, synchronous to clk.
REQ-008 evt_valid  output  1  queue head holds an event.
REQ-009 evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-010 evt_data  output  2+3  {type[1:0], key_id[2:0]}; type 00 press, 01 release, 10 long, 11 repeat.
REQ-011 evt_drop  output  1  one-cycle pulse: an event was lost.

Function
REQ-012 Each key SHALL keep a registered copy key_q; a change is key_in[i] != key_q[i] at an edge, after which key_q[i] updates.
REQ-013 Per-key FSM SHALL have states IDLE, PRESSED, HELD, with a per-key hold counter.
REQ-014 IDLE->PRESSED on rising change: press event, counter cleared.
REQ-015 PRESSED: counter increments each cycle; at LONG_CYCLES-1 with key still pressed: long event, ->HELD, counter cleared.
REQ-016 PRESSED or HELD->IDLE on falling change: release event, counter cleared; release in the cycle the counter hits its limit SHALL produce only the release.
REQ-017 Each event SHALL set a per-key single-entry pending register on the edge where it is detected.
REQ-018 An event for a key whose pending register is still set SHALL be discarded, evt_drop pulsed next cycle.
REQ-019 Arbiter: each cycle, when the queue is not full, SHALL move the lowest-index pending event into the queue and clear that pending bit; one push per cycle.
REQ-020 Push SHALL require not-full; a pop in the same cycle does not permit a push into a full queue.
REQ-021 Latency: key change at edge t -> evt_valid high after edge t+1 when queue empty and no lower-index key pending.
REQ-022 Pop occurs on an edge with evt_valid & evt_ready; evt_data stable while evt_valid=1 and evt_ready=0.
REQ-023 Queue SHALL be FIFO-ordered; pointers wrap modulo FIFO_DEPTH; push and pop in the same cycle on a non-full, non-empty queue keep occupancy unchanged.
REQ-024 Simultaneous changes on several keys SHALL all be recorded as pending in the same cycle and queued in ascending key index over subsequent cycles.

Reset
REQ-025 On nrst=0: key_q, FSMs (IDLE), counters, pending bits, queue pointers cleared; evt_valid=0, evt_data=0, evt_drop=0, asynchronously.
REQ-026 Keys held at reset release SHALL produce a press event as a normal rising change.
REQ-027 Reset mid-operation SHALL discard all queued and pending events without evt_drop.

Configuration
REQ-028 Macro KEY_REPEAT_EN defined: in HELD, counter increments; at REPEAT_CYCLES-1, repeat event and counter cleared, repeating until release.
REQ-029 Macro KEY_REPEAT_EN undefined: HELD counter is held at 0, type 11 is never produced, repeat logic absent.

Verification
REQ-030 Key 0 pressed 5 cycles then released, evt_ready=1 -> press(00,0) then release(01,0); no long.
REQ-031 Key 2 held 40 cycles, LONG_CYCLES=16 -> press, long at 16 cycles after press; with KEY_REPEAT_EN repeats every 8 cycles (2 repeats), then release.
REQ-032 Keys 3,1,0 pressed same cycle -> events key 0, 1, 3 on consecutive cycles.
REQ-033 evt_ready=0, 6 events generated -> 4 queued, pending absorbs, further same-key event raises evt_drop; draining yields events in order.
REQ-034 Key 1 released exactly at counter LONG_CYCLES-1 -> release only, no long event.
REQ-035 nrst asserted with 3 queued events and key 0 held -> evt_valid=0 immediately; after release of reset press(00,0) is the first event.

Source files
------------

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_event_ctrl
// Description : Per-key press/release/long(/repeat) event generator feeding a
//               single-entry pending slot per key, a lowest-index-first
//               arbiter and an event FIFO with valid/ready handshake.
//               Optional feature macro: KEY_REPEAT_EN (auto-repeat in HELD).
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_ctrl #(
    parameter int NKEYS         = 4,
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NKEYS-1:0] key_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [4:0]       evt_data,
    output logic             evt_drop
);

    localparam int c_CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_AW      = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_T_PRESS   = 2'b00;
    localparam logic [1:0] c_T_RELEASE = 2'b01;
    localparam logic [1:0] c_T_LONG    = 2'b10;
`ifdef KEY_REPEAT_EN
    localparam logic [1:0] c_T_REPEAT  = 2'b11;
    localparam logic [c_CNT_W-1:0] c_REP_LAST = c_CNT_W'(REPEAT_CYCLES - 1);
`endif
    localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(LONG_CYCLES - 1);
    localparam logic [c_AW:0]      c_FULL_CNT  = (c_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t               r_state     [NKEYS];
    state_t               w_state_nxt [NKEYS];
    logic [c_CNT_W-1:0]   r_cnt       [NKEYS];
    logic [c_CNT_W-1:0]   w_cnt_nxt   [NKEYS];
    logic [1:0]           w_evt_type  [NKEYS];
    logic [1:0]           r_pend_type [NKEYS];
    logic [NKEYS-1:0]     r_key_q;
    logic [NKEYS-1:0]     w_rise;
    logic [NKEYS-1:0]     w_fall;
    logic [NKEYS-1:0]     w_evt;
    logic [NKEYS-1:0]     r_pend_v;
    logic [NKEYS-1:0]     w_grant;
    logic [2:0]           w_grant_id;
    logic [1:0]           w_grant_type;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_drop;
    logic                 r_drop;
    logic [4:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;

    assign w_rise = key_in & ~r_key_q;
    assign w_fall = ~key_in & r_key_q;

    // Registered copy of the key levels, used for edge (change) detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_key_q <= '0;
        else       r_key_q <= key_in;
    end

    // Per-key FSM state and hold-counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NKEYS; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Per-key next state, counter and event detection; release beats long/repeat.
    always_comb begin
        w_evt = '0;
        for (int i = 0; i < NKEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_evt_type[i]  = c_T_PRESS;
            case (r_state[i])
                S_IDLE: begin
                    if (w_rise[i]) begin
                        w_state_nxt[i] = S_PRESSED;
                        w_cnt_nxt[i]   = '0;
                        w_evt[i]       = 1'b1;
                        w_evt_type[i]  = c_T_PRESS;
                    end
                end
                S_PRESSED: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                        w_evt[i]       = 1'b1;
                        w_evt_type[i]  = c_T_RELEASE;
                    end else if (r_cnt[i] == c_LONG_LAST) begin
                        w_state_nxt[i] = S_HELD;
                        w_cnt_nxt[i]   = '0;
                        w_evt[i]       = 1'b1;
                        w_evt_type[i]  = c_T_LONG;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + c_CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                        w_evt[i]       = 1'b1;
                        w_evt_type[i]  = c_T_RELEASE;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (r_cnt[i] == c_REP_LAST) begin
                            w_cnt_nxt[i]  = '0;
                            w_evt[i]      = 1'b1;
                            w_evt_type[i] = c_T_REPEAT;
                        end else begin
                            w_cnt_nxt[i]  = r_cnt[i] + c_CNT_W'(1);
                        end
`else
                        w_cnt_nxt[i] = '0;
`endif
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Arbiter: lowest-index pending key wins the single push slot when not full.
    always_comb begin
        w_grant      = '0;
        w_grant_id   = '0;
        w_grant_type = c_T_PRESS;
        if (!w_full) begin
            for (int i = NKEYS - 1; i >= 0; i--) begin
                if (r_pend_v[i]) begin
                    w_grant      = '0;
                    w_grant[i]   = 1'b1;
                    w_grant_id   = 3'(i);
                    w_grant_type = r_pend_type[i];
                end
            end
        end
    end

    assign w_push = |w_grant;
    assign w_pop  = evt_valid & evt_ready;
    assign w_full = (r_count == c_FULL_CNT);
    // A slot being drained this cycle is free to accept the new event.
    assign w_drop = |(w_evt & r_pend_v & ~w_grant);

    // Pending slots: capture new events, clear on grant, keep old entry on collision.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pend_v <= '0;
            for (int i = 0; i < NKEYS; i++) r_pend_type[i] <= c_T_PRESS;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (w_evt[i] && !(r_pend_v[i] && !w_grant[i])) begin
                    r_pend_v[i]    <= 1'b1;
                    r_pend_type[i] <= w_evt_type[i];
                end else if (w_grant[i]) begin
                    r_pend_v[i]    <= 1'b0;
                end
            end
        end
    end

    // Lost-event pulse, one cycle after the collision.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_drop <= 1'b0;
        else       r_drop <= w_drop;
    end

    // FIFO storage; contents are only visible while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_grant_type, w_grant_id};
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 5'd0;
    assign evt_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_ctrl
// Description : Scoreboard bench for key_event_ctrl. A behavioural model,
//               stepped on each rising edge, pushes expected events into a
//               queue; a monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

    localparam int NK     = 4;
    localparam int LONG   = 16;
    localparam int REPEAT = 8;
    localparam int DEPTH  = 4;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [NK-1:0] key_in = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [4:0]    evt_data;
    logic          evt_drop;

    int n_pass  = 0;
    int n_total = 0;

    key_event_ctrl #(
        .NKEYS(NK), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .nrst(nrst), .key_in(key_in), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_data(evt_data), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int       held [NK];
    bit       kq   [NK];
    bit       pv   [NK];
    bit [1:0] pt   [NK];
    bit       ev   [NK];
    bit [1:0] et   [NK];
    bit [4:0] exp_q [$];
    bit       pop_pending = 1'b0;
    bit       exp_drop = 1'b0;
    int       occ;
    int       g;

    initial begin
        for (int i = 0; i < NK; i++) begin
            held[i] = 0; kq[i] = 0; pv[i] = 0; pt[i] = 0;
        end
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                for (int i = 0; i < NK; i++) begin
                    held[i] = 0; kq[i] = 0; pv[i] = 0; pt[i] = 0;
                end
                exp_q.delete();
                pop_pending = 1'b0;
                exp_drop    = 1'b0;
            end else begin
                occ = exp_q.size() + (pop_pending ? 1 : 0);
                pop_pending = 1'b0;
                // key events from level history: long at LONG cycles after press,
                // repeats every REPEAT cycles after that; release always wins
                for (int i = 0; i < NK; i++) begin
                    ev[i] = 1'b0; et[i] = 2'b00;
                    if (key_in[i] && !kq[i]) begin
                        ev[i] = 1'b1; et[i] = 2'b00; held[i] = 0;
                    end else if (!key_in[i] && kq[i]) begin
                        ev[i] = 1'b1; et[i] = 2'b01;
                    end else if (key_in[i]) begin
                        held[i]++;
                        if (held[i] == LONG) begin
                            ev[i] = 1'b1; et[i] = 2'b10;
                        end else if (REPEAT_ON && held[i] > LONG && ((held[i] - LONG) % REPEAT) == 0) begin
                            ev[i] = 1'b1; et[i] = 2'b11;
                        end
                    end
                    kq[i] = key_in[i];
                end
                // lowest pending key moves into queue if there is room
                g = -1;
                if (occ < DEPTH)
                    for (int i = NK - 1; i >= 0; i--) if (pv[i]) g = i;
                if (g >= 0) begin
                    exp_q.push_back({pt[g], 3'(g)});
                    pv[g] = 1'b0;
                end
                exp_drop = 1'b0;
                for (int i = 0; i < NK; i++) begin
                    if (ev[i]) begin
                        if (pv[i]) exp_drop = 1'b1;
                        else begin pv[i] = 1'b1; pt[i] = et[i]; end
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit [4:0] exp_evt;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!nrst) begin
                chk("rst_valid", int'(evt_valid), 0);
                chk("rst_drop",  int'(evt_drop), 0);
                chk("rst_data",  int'(evt_data), 0);
            end else begin
                chk("valid", int'(evt_valid), (exp_q.size() != 0) ? 1 : 0);
                chk("drop",  int'(evt_drop), int'(exp_drop));
                if (evt_ready && exp_q.size() != 0) begin
                    exp_evt = exp_q.pop_front();
                    chk("evt_data", int'(evt_data), int'(exp_evt));
                    pop_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int waited;

    initial begin
        tick(3);
        nrst = 1'b1;
        tick(2);

        // single short press, consumer always ready
        evt_ready = 1'b1;
        key_in = 4'b0001; tick(5);
        key_in = 4'b0000; tick(8);

        // long hold of key 2 (long, and repeats when enabled)
        key_in = 4'b0100; tick(40);
        key_in = 4'b0000; tick(8);

        // simultaneous presses queue in ascending index
        key_in = 4'b1011; tick(4);
        key_in = 4'b0000; tick(10);

        // back-pressure: fill queue, occupy pending slots, force drops, drain
        evt_ready = 1'b0;
        key_in = 4'b1111; tick(6);
        key_in = 4'b1100; tick(1);
        key_in = 4'b1101; tick(2);
        key_in = 4'b0000; tick(3);
        evt_ready = 1'b1; tick(15);

        // release exactly when the counter reaches its limit: release only
        key_in = 4'b0010; tick(LONG);
        key_in = 4'b0000; tick(8);

        // reset mid-operation with queued events and keys held
        evt_ready = 1'b0;
        key_in = 4'b1110; tick(6);
        key_in = 4'b1111; tick(2);
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_valid", int'(evt_valid), 0);
        chk("async_rst_drop",  int'(evt_drop), 0);
        tick(3);
        nrst = 1'b1;
        waited = 0;
        while (!evt_valid && waited < 10) begin tick(1); #1; waited++; end
        chk("post_rst_first_valid", int'(evt_valid), 1);
        chk("post_rst_first_evt",   int'(evt_data), 0);
        evt_ready = 1'b1;
        key_in = 4'b0000; tick(20);

        // randomized traffic with moderate then heavy back-pressure
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 11) == 0) key_in[k] = ~key_in[k];
            evt_ready = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick(1);
        end

        // drain
        key_in = 4'b0000;
        evt_ready = 1'b1;
        tick(40);
        #1;
        chk("drain_empty_model", exp_q.size(), 0);
        chk("drain_empty_dut",   int'(evt_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
